// File: rtl/cpu_trace_buffer_pkg.sv
// Shared definitions for the CPU execution-trace buffer: FSM state encoding
// and the entry-width helper used to size the trace storage.
// The optional per-entry timestamp is enabled with the TRACE_STAMP_EN macro.
package cpu_trace_buffer_pkg;

  // Capture FSM states; the encoding is visible on the state output port
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Packed entry layout, LSB first: wb_data, wb_addr, wb_en, instr, pc, stamp
  function automatic int entry_width(input int pc_w, input int instr_w,
                                     input int data_w, input int addr_w,
                                     input int stamp_w);
    return data_w + addr_w + 1 + instr_w + pc_w + stamp_w;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_trace_ram.sv
// trace_ram: DEPTH x WIDTH trace storage with one synchronous write port and
// one asynchronous read port, so the oldest entry falls through to the reader.
module trace_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the incoming entry on the rising edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: captures retired instructions into a circular buffer with
// a PC-match trigger, stop-on-full or wrap modes, and a FWFT drain port.
// Define TRACE_STAMP_EN to store a free-running cycle stamp with each entry
// and expose it on rd_stamp.
module cpu_trace_buffer
  import cpu_trace_buffer_pkg::*;
#(
  parameter int PC_W       = 8,
  parameter int INSTR_W    = 16,
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int DEPTH      = 16,
  parameter int STAMP_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arm,
  input  logic                         stop,
  input  logic                         mode_wrap,
  input  logic                         trig_en,
  input  logic [PC_W-1:0]              trig_pc,
  input  logic                         ret_valid,
  input  logic [PC_W-1:0]              ret_pc,
  input  logic [INSTR_W-1:0]           ret_instr,
  input  logic                         ret_wb_en,
  input  logic [REG_ADDR_W-1:0]        ret_wb_addr,
  input  logic [DATA_W-1:0]            ret_wb_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [PC_W-1:0]              rd_pc,
  output logic [INSTR_W-1:0]           rd_instr,
  output logic                         rd_wb_en,
  output logic [REG_ADDR_W-1:0]        rd_wb_addr,
  output logic [DATA_W-1:0]            rd_wb_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [1:0]                   state,
  output logic                         overflow
`ifdef TRACE_STAMP_EN
  ,output logic [STAMP_W-1:0]          rd_stamp
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
`ifdef TRACE_STAMP_EN
  localparam int S_W = STAMP_W;
`else
  // Stamp field is absent from the entry when stamping is not built in
  localparam int S_W = 0 * STAMP_W;
`endif
  localparam int ENTRY_W   = entry_width(PC_W, INSTR_W, DATA_W, REG_ADDR_W, S_W);
  localparam int OFF_DATA  = 0;
  localparam int OFF_ADDR  = OFF_DATA + DATA_W;
  localparam int OFF_WBEN  = OFF_ADDR + REG_ADDR_W;
  localparam int OFF_INSTR = OFF_WBEN + 1;
  localparam int OFF_PC    = OFF_INSTR + INSTR_W;
  localparam int OFF_STAMP = OFF_PC + PC_W;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               overflow_reg, overflow_next;
  logic               wr_en;
  logic               full;
  logic               pop;
  logic               capture;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] ram_rdata;
  logic [ENTRY_W-1:0] rd_entry;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign rd_valid = (count_reg != '0);
  assign pop      = rd_valid && rd_ready;

  // A retire is eligible when armed and matching the trigger, or while capturing
  assign capture = ret_valid &&
                   (((state_reg == ST_ARMED) && (!trig_en || (ret_pc == trig_pc))) ||
                    (state_reg == ST_CAPTURE));

  // Pack the retire fields into one storage word
  assign wr_entry[OFF_DATA  +: DATA_W]     = ret_wb_data;
  assign wr_entry[OFF_ADDR  +: REG_ADDR_W] = ret_wb_addr;
  assign wr_entry[OFF_WBEN]                = ret_wb_en;
  assign wr_entry[OFF_INSTR +: INSTR_W]    = ret_instr;
  assign wr_entry[OFF_PC    +: PC_W]       = ret_pc;

`ifdef TRACE_STAMP_EN
  logic [STAMP_W-1:0] stamp_reg;

  // Free-running cycle stamp, restarted by reset and by arm
  always_ff @(posedge clk) begin
    if (rst || arm) begin
      stamp_reg <= '0;
    end else begin
      stamp_reg <= stamp_reg + STAMP_W'(1);
    end
  end

  assign wr_entry[OFF_STAMP +: STAMP_W] = stamp_reg;
  assign rd_stamp = rd_entry[OFF_STAMP +: STAMP_W];
`endif

  trace_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_trace_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_reg),
    .wdata (wr_entry),
    .raddr (rd_ptr_reg),
    .rdata (ram_rdata)
  );

  // Uninitialised storage is hidden while empty so rd_* read as zero
  assign rd_entry   = rd_valid ? ram_rdata : '0;
  assign rd_pc      = rd_entry[OFF_PC    +: PC_W];
  assign rd_instr   = rd_entry[OFF_INSTR +: INSTR_W];
  assign rd_wb_en   = rd_entry[OFF_WBEN];
  assign rd_wb_addr = rd_entry[OFF_ADDR  +: REG_ADDR_W];
  assign rd_wb_data = rd_entry[OFF_DATA  +: DATA_W];

  assign count    = count_reg;
  assign state    = state_reg;
  assign overflow = overflow_reg;

  // State, pointer, occupancy and overflow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Next-state logic: arm beats stop, stop beats capture; pops proceed unless arming
  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    wr_en         = 1'b0;

    if (arm) begin
      state_next    = ST_ARMED;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
      overflow_next = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        count_next  = count_reg - CNT_W'(1);
      end

      if (stop && ((state_reg == ST_ARMED) || (state_reg == ST_CAPTURE))) begin
        state_next = ST_DONE;
      end else if (capture) begin
        if (!full || pop) begin
          // A same-cycle pop frees the slot, so a full buffer still accepts
          wr_en       = 1'b1;
          wr_ptr_next = wr_ptr_reg + PTR_W'(1);
          count_next  = pop ? count_reg : count_reg + CNT_W'(1);
          state_next  = ST_CAPTURE;
        end else if (mode_wrap) begin
          // Keep newest: overwrite the oldest slot and drag the read pointer along
          wr_en         = 1'b1;
          wr_ptr_next   = wr_ptr_reg + PTR_W'(1);
          rd_ptr_next   = rd_ptr_reg + PTR_W'(1);
          overflow_next = 1'b1;
        end else begin
          overflow_next = 1'b1;
          state_next    = ST_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer (DEPTH=4): a queue-based model of
// the trace rules is compared with the DUT every cycle, plus literal checks.
module tb_cpu_trace_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        wb_en;
    logic [2:0]  addr;
    logic [7:0]  data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, arm, stop, mode_wrap, trig_en, ret_valid, ret_wb_en, rd_ready;
  logic [7:0]  trig_pc, ret_pc, ret_wb_data;
  logic [15:0] ret_instr;
  logic [2:0]  ret_wb_addr;
  logic        rd_valid, rd_wb_en, overflow;
  logic [7:0]  rd_pc, rd_wb_data;
  logic [15:0] rd_instr;
  logic [2:0]  rd_wb_addr, count;
  logic [1:0]  state;
`ifdef TRACE_STAMP_EN
  logic [15:0] rd_stamp;
`endif

  int errors = 0;
  int checks = 0;

  cpu_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .mode_wrap(mode_wrap),
    .trig_en(trig_en), .trig_pc(trig_pc), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_instr(ret_instr), .ret_wb_en(ret_wb_en), .ret_wb_addr(ret_wb_addr),
    .ret_wb_data(ret_wb_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_wb_en(rd_wb_en), .rd_wb_addr(rd_wb_addr),
    .rd_wb_data(rd_wb_data), .count(count), .state(state), .overflow(overflow)
`ifdef TRACE_STAMP_EN
    , .rd_stamp(rd_stamp)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue holding the buffered entries, oldest first
  ent_t mq[$];
  int   m_state = 0;
  bit   m_ovf = 0;
  bit   m_started = 0;
  bit   m_pop, m_hit;
  ent_t m_cur;

  always @(posedge clk) begin
    m_started = 1;
    m_cur = '{pc: ret_pc, instr: ret_instr, wb_en: ret_wb_en, addr: ret_wb_addr, data: ret_wb_data};
    if (rst) begin
      mq.delete(); m_state = 0; m_ovf = 0;
    end else if (arm) begin
      mq.delete(); m_state = 1; m_ovf = 0;
    end else begin
      m_pop = (mq.size() != 0) && rd_ready;
      if (m_pop) void'(mq.pop_front());
      m_hit = ret_valid && ((m_state == 1 && (!trig_en || ret_pc == trig_pc)) || m_state == 2);
      if (stop && (m_state == 1 || m_state == 2)) begin
        m_state = 3;
      end else if (m_hit) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(m_cur); m_state = 2;
        end else if (mode_wrap) begin
          void'(mq.pop_front()); mq.push_back(m_cur); m_ovf = 1;
        end else begin
          m_ovf = 1; m_state = 3;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_started) begin
      check("cyc_rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
      check("cyc_count",    32'(count),    32'(mq.size()));
      check("cyc_state",    32'(state),    32'(m_state));
      check("cyc_overflow", 32'(overflow), 32'(m_ovf));
      if (mq.size() != 0) begin
        check("cyc_rd_entry", {rd_pc, rd_instr, rd_wb_en, rd_wb_addr, rd_wb_data} , 32'(mq[0]) );
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [7:0] pc);
    ret_valid   = 1'b1;
    ret_pc      = pc;
    ret_instr   = {8'hA5, pc};
    ret_wb_en   = pc[0];
    ret_wb_addr = pc[2:0];
    ret_wb_data = pc ^ 8'hFF;
    tick();
    ret_valid   = 1'b0;
    $display("retire pc=%0d -> state=%0d count=%0d ovf=%0d", pc, state, count, overflow);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] pc);
    check(name, 32'(rd_pc), 32'(pc));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    $display("pop pc=%0d -> count=%0d", pc, count);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    $display("arm -> state=%0d count=%0d", state, count);
  endtask

  initial begin
    rst = 1'b1; arm = 0; stop = 0; mode_wrap = 0; trig_en = 0; trig_pc = 0;
    ret_valid = 1'b1; ret_pc = 8'd9; ret_instr = 16'h1234; ret_wb_en = 1;
    ret_wb_addr = 3'd1; ret_wb_data = 8'h55; rd_ready = 0;

    // 1. Reset with a retire present
    tick(); tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rd_pc", 32'(rd_pc), 32'd0);
    rst = 1'b0; ret_valid = 1'b0;
    $display("reset released -> state=%0d count=%0d", state, count);

    // 2. Free capture and in-order drain
    do_arm();
    retire(8'd0); retire(8'd1); retire(8'd2);
    check("t2_count", 32'(count), 32'd3);
    check("t2_instr", 32'(rd_instr), 32'hA500);
    pop_expect("t2_pop0", 8'd0);
    pop_expect("t2_pop1", 8'd1);
    pop_expect("t2_pop2", 8'd2);
    check("t2_empty", 32'(rd_valid), 32'd0);

    // 3. Trigger on pc 5
    trig_en = 1'b1; trig_pc = 8'd5;
    do_arm();
    retire(8'd3);
    check("t3_armed", 32'(state), 32'd1);
    retire(8'd4);
    retire(8'd5);
    check("t3_state", 32'(state), 32'd2);
    retire(8'd6);
    check("t3_count", 32'(count), 32'd2);
    check("t3_head", 32'(rd_pc), 32'd5);
    trig_en = 1'b0;

    // 4. Stop when full
    mode_wrap = 1'b0;
    do_arm();
    for (int p = 10; p <= 15; p++) retire(8'(p));
    check("t4_count", 32'(count), 32'd4);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_state", 32'(state), 32'd3);
    for (int p = 10; p <= 13; p++) pop_expect("t4_pop", 8'(p));

    // 5. Wrap keeping newest, then push+pop while full
    mode_wrap = 1'b1;
    do_arm();
    for (int p = 10; p <= 15; p++) retire(8'(p));
    check("t5_count", 32'(count), 32'd4);
    check("t5_overflow", 32'(overflow), 32'd1);
    check("t5_state", 32'(state), 32'd2);
    check("t5_head", 32'(rd_pc), 32'd12);
    do_arm();
    for (int p = 20; p <= 23; p++) retire(8'(p));
    check("t5_full_noovf", 32'(overflow), 32'd0);
    rd_ready = 1'b1;
    retire(8'd24);
    rd_ready = 1'b0;
    check("t5_pp_count", 32'(count), 32'd4);
    check("t5_pp_overflow", 32'(overflow), 32'd0);
    check("t5_pp_head", 32'(rd_pc), 32'd21);

    // 6. Re-arm mid-capture, stop, then reset during capture
    do_arm();
    retire(8'd1); retire(8'd2); retire(8'd3);
    check("t6_count3", 32'(count), 32'd3);
    do_arm();
    check("t6_rearm_count", 32'(count), 32'd0);
    check("t6_rearm_state", 32'(state), 32'd1);
    retire(8'd8);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t6_stop_state", 32'(state), 32'd3);
    retire(8'd9);
    check("t6_done_count", 32'(count), 32'd1);
    do_arm();
    retire(8'd7);
    check("t6_cap_state", 32'(state), 32'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_rst_state", 32'(state), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
